// File: rtl/rename_pkg.sv
// rename_pkg: shared constants, types and the x0 write-drop helper for the rename tables
package rename_pkg;
  localparam int LREG_W = 5;
  localparam int NUM_LREG = 32;
  localparam int DEF_NUM_CKPT = 4;
  typedef logic [$clog2(DEF_NUM_CKPT)-1:0] ckpt_id_t;
  function automatic logic wr_keep(input logic v, input logic [LREG_W-1:0] lrd);
    return v && (lrd != '0);
  endfunction
endpackage

// File: rtl/rat_ckpt_buffer.sv
// rat_ckpt_buffer: circular buffer of spec-RAT snapshots with alloc, free, truncate-on-redirect and clear
module rat_ckpt_buffer
  import rename_pkg::*;
#(
  parameter int PREG_W = 6,
  parameter int NUM_CKPT = 4,
  localparam int IW = $clog2(NUM_CKPT),
  localparam int PW = IW + 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       alloc,
  input  logic                       free,
  input  logic                       redirect,
  input  logic                       clear,
  input  logic [IW-1:0]              redirect_id,
  input  logic [NUM_LREG*PREG_W-1:0] snap,
  output logic                       ready,
  output logic [IW-1:0]              alloc_id,
  output logic                       hit,
  output logic [NUM_LREG*PREG_W-1:0] restore
);
  logic [NUM_LREG*PREG_W-1:0] mem [NUM_CKPT];
  logic [PW-1:0] head, tail, count, off;
  logic alloc_ok, free_ok;
  assign ready = count != PW'(NUM_CKPT);
  assign alloc_id = tail[IW-1:0];
  // distance of the requested id from the oldest live entry; live iff below count
  assign off = {1'b0, redirect_id - head[IW-1:0]};
  assign hit = redirect && off < count;
  assign alloc_ok = alloc && ready && !hit && !clear;
  assign free_ok = free && count != '0 && !clear;
  assign restore = mem[redirect_id];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(free_ok);
      tail <= hit ? head + off + PW'(1) : tail + PW'(alloc_ok);
      count <= hit ? off + PW'(1) - PW'(free_ok) : count + PW'(alloc_ok) - PW'(free_ok);
    end
  always_ff @(posedge clock)
    if (alloc_ok) mem[tail[IW-1:0]] <= snap;
endmodule

// File: rtl/spec_rename_table.sv
// spec_rename_table: speculative RAT with bypassed lookups, checkpoint recovery and commit-driven arch RAT
module spec_rename_table
  import rename_pkg::*;
#(
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int PREG_W = 6,
  parameter int NUM_CKPT = 4,
  localparam int IW = $clog2(NUM_CKPT)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [RENAME_WIDTH-1:0]          rd_src1_is_reg,
  input  logic [RENAME_WIDTH-1:0]          rd_src2_is_reg,
  input  logic [RENAME_WIDTH-1:0]          rd_need_wb,
  input  logic [LREG_W*RENAME_WIDTH-1:0]   rd_lrs1,
  input  logic [LREG_W*RENAME_WIDTH-1:0]   rd_lrs2,
  input  logic [LREG_W*RENAME_WIDTH-1:0]   rd_lrd,
  output logic [PREG_W*RENAME_WIDTH-1:0]   rd_prs1,
  output logic [PREG_W*RENAME_WIDTH-1:0]   rd_prs2,
  output logic [PREG_W*RENAME_WIDTH-1:0]   rd_old_prd,
  input  logic [RENAME_WIDTH-1:0]          wr_valid,
  input  logic [LREG_W*RENAME_WIDTH-1:0]   wr_lrd,
  input  logic [PREG_W*RENAME_WIDTH-1:0]   wr_prd,
  input  logic                             ckpt_alloc_valid,
  output logic                             ckpt_alloc_ready,
  output logic [IW-1:0]                    ckpt_alloc_id,
  input  logic                             ckpt_free_valid,
  input  logic                             redirect_valid,
  input  logic [IW-1:0]                    redirect_id,
  input  logic                             flush_valid,
  input  logic [COMMIT_WIDTH-1:0]          cm_valid,
  input  logic [COMMIT_WIDTH-1:0]          cm_need_wb,
  input  logic [LREG_W*COMMIT_WIDTH-1:0]   cm_lrd,
  input  logic [PREG_W*COMMIT_WIDTH-1:0]   cm_prd,
  output logic [NUM_LREG*PREG_W-1:0]       debug_arch_rat
);
  logic [PREG_W-1:0] spec_rat [NUM_LREG];
  logic [PREG_W-1:0] arch_rat [NUM_LREG];
  logic [PREG_W-1:0] spec_wr [NUM_LREG];
  logic [PREG_W-1:0] arch_nx [NUM_LREG];
  logic [PREG_W-1:0] ckpt_rat [NUM_LREG];
  logic [NUM_LREG*PREG_W-1:0] snap, restore;
  logic hit;
  // later slots overwrite earlier ones, so the youngest write wins
  always_comb begin
    spec_wr = spec_rat;
    arch_nx = arch_rat;
    for (int k = 0; k < RENAME_WIDTH; k++)
      if (wr_keep(wr_valid[k], wr_lrd[LREG_W*k+:LREG_W])) spec_wr[wr_lrd[LREG_W*k+:LREG_W]] = wr_prd[PREG_W*k+:PREG_W];
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (wr_keep(cm_valid[k] && cm_need_wb[k], cm_lrd[LREG_W*k+:LREG_W])) arch_nx[cm_lrd[LREG_W*k+:LREG_W]] = cm_prd[PREG_W*k+:PREG_W];
  end
  for (genvar i = 0; i < NUM_LREG; i++) begin : g_pack
    assign snap[PREG_W*i+:PREG_W] = spec_wr[i];
    assign ckpt_rat[i] = restore[PREG_W*i+:PREG_W];
    assign debug_arch_rat[PREG_W*i+:PREG_W] = arch_rat[i];
  end
  rat_ckpt_buffer #(.PREG_W(PREG_W), .NUM_CKPT(NUM_CKPT)) u_ckpt (
    .clock(clock),
    .reset_n(reset_n),
    .alloc(ckpt_alloc_valid),
    .free(ckpt_free_valid),
    .redirect(redirect_valid),
    .clear(flush_valid),
    .redirect_id(redirect_id),
    .snap(snap),
    .ready(ckpt_alloc_ready),
    .alloc_id(ckpt_alloc_id),
    .hit(hit),
    .restore(restore)
  );
  function automatic logic [PREG_W-1:0] look(input logic en, input logic [LREG_W-1:0] idx);
    logic [PREG_W-1:0] r;
    r = spec_rat[idx];
    for (int j = 0; j < RENAME_WIDTH; j++)
      if (wr_keep(wr_valid[j], wr_lrd[LREG_W*j+:LREG_W]) && wr_lrd[LREG_W*j+:LREG_W] == idx) r = wr_prd[PREG_W*j+:PREG_W];
    return en ? r : '0;
  endfunction
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_LREG; i++) begin
        spec_rat[i] <= PREG_W'(i);
        arch_rat[i] <= PREG_W'(i);
      end
    end else begin
      arch_rat <= arch_nx;
      if (flush_valid) spec_rat <= arch_nx;
      else if (hit) spec_rat <= ckpt_rat;
      else spec_rat <= spec_wr;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rd_prs1 <= '0;
      rd_prs2 <= '0;
      rd_old_prd <= '0;
    end else begin
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        rd_prs1[PREG_W*k+:PREG_W] <= look(rd_src1_is_reg[k], rd_lrs1[LREG_W*k+:LREG_W]);
        rd_prs2[PREG_W*k+:PREG_W] <= look(rd_src2_is_reg[k], rd_lrs2[LREG_W*k+:LREG_W]);
        rd_old_prd[PREG_W*k+:PREG_W] <= look(rd_need_wb[k], rd_lrd[LREG_W*k+:LREG_W]);
      end
    end
endmodule
